// File: rtl/bus_pkg.sv
// Shared arbiter types: FSM state encoding and priority-mode constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        UTIL,
        SPLIT,
        SPLIT_UTIL,
        SPLIT_RESUME
    } arb_state_t;

    localparam logic PRIO_FIXED = 1'b0;
    localparam logic PRIO_RR    = 1'b1;

endpackage

// File: rtl/bus_arbiter_nx_if.sv
// Arbitration bus bundle: per-master requests, one-hot grant, transfer and split handshakes.
// Latency: n/a (wires only).
// Backpressure: requesters hold B_REQ until granted; grant holder signals B_UTIL/B_DONE.
interface bus_arbiter_nx_if #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 3
);
    logic [NUM_MASTERS-1:0] B_REQ;
    logic [NUM_MASTERS-1:0] B_GRANT;
    logic                   B_UTIL;
    logic                   B_DONE;
    logic [NUM_SLAVES-1:0]  B_SBSY;
    logic [NUM_SLAVES-1:0]  B_SPL_RDY;
    logic                   B_SPLIT;
    logic                   B_SPL_RESUME;

    // Arbiter side.
    modport master (
        input  B_REQ, B_UTIL, B_DONE, B_SBSY, B_SPL_RDY,
        output B_GRANT, B_SPLIT, B_SPL_RESUME
    );

    // Requesting masters and split-capable slaves.
    modport slave (
        output B_REQ, B_UTIL, B_DONE, B_SBSY, B_SPL_RDY,
        input  B_GRANT, B_SPLIT, B_SPL_RESUME
    );
endinterface

// File: rtl/arb_pick.sv
// Winner search: fixed (lowest index) or round-robin (first after ptr) over req & ~mask.
// Latency: purely combinational.
// Backpressure: none; found=0 when no eligible requester.
module arb_pick
    import bus_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);
    localparam int PW = IW + 1;

    logic [N-1:0] eligible;
    logic [PW-1:0] pos;

    assign eligible = req & ~mask;

    // pos never exceeds 2N-1, so one conditional subtract implements the wrap.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            if (mode == PRIO_RR) begin
                pos = {1'b0, ptr} + PW'(k + 1);
            end else begin
                pos = PW'(k);
            end
            if (pos >= PW'(N)) begin
                pos = pos - PW'(N);
            end
            if (!found && eligible[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
        if (found) begin
            grant[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/bus_arbiter_nx.sv
// Bus arbiter with grant timeout and a single outstanding split transaction.
// Latency: grant/split/resume outputs registered, one cycle after the deciding inputs.
// Backpressure: none; a grantee is never preempted, only revoked before B_UTIL.
module bus_arbiter_nx
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int NUM_SLAVES    = 3,
    parameter int PRIO_MODE     = 0,
    parameter int GRANT_TIMEOUT = 15
) (
    input logic              CLK,
    input logic              RSTN,
    bus_arbiter_nx_if.master bus
);
    localparam int MW = $clog2(NUM_MASTERS);
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TW = $clog2(GRANT_TIMEOUT + 1);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   split_q, split_d;
    logic                   resume_q, resume_d;
    logic                   spl_rdy_q, spl_rdy_d;
    logic [TW-1:0]          tmo_q, tmo_d, tmo_inc;
    logic [MW-1:0]          spl_mst_q, spl_mst_d;
    logic [SW-1:0]          spl_slv_q, spl_slv_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [MW-1:0]          gnt_idx_q, gnt_idx_d;

    logic [NUM_MASTERS-1:0] pick_mask, pick_grant, mst_onehot;
    logic [MW-1:0]          pick_idx;
    logic                   pick_found;
    logic [SW-1:0]          sbsy_idx;
    logic                   rdy_hit;

    assign mst_onehot = NUM_MASTERS'(1) << spl_mst_q;
    // The split owner is excluded while another master borrows the bus.
    assign pick_mask  = (state_q == SPLIT) ? mst_onehot : '0;
    assign rdy_hit    = bus.B_SPL_RDY[spl_slv_q];
    assign tmo_inc    = (tmo_q == TW'(GRANT_TIMEOUT)) ? tmo_q : tmo_q + TW'(1);

    arb_pick #(
        .N(NUM_MASTERS)
    ) u_pick (
        .req  (bus.B_REQ),
        .mask (pick_mask),
        .ptr  (rr_ptr_q),
        .mode ((PRIO_MODE == 1) ? PRIO_RR : PRIO_FIXED),
        .grant(pick_grant),
        .idx  (pick_idx),
        .found(pick_found)
    );

    always_comb begin
        sbsy_idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (bus.B_SBSY[k]) begin
                sbsy_idx = SW'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        split_d   = split_q;
        resume_d  = resume_q;
        tmo_d     = tmo_q;
        spl_mst_d = spl_mst_q;
        spl_slv_d = spl_slv_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        spl_rdy_d = spl_rdy_q;
        if ((state_q == SPLIT || state_q == SPLIT_UTIL) && rdy_hit) begin
            spl_rdy_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pick_found && !bus.B_DONE) begin
                    grant_d   = pick_grant;
                    gnt_idx_d = pick_idx;
                    tmo_d     = '0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                tmo_d = tmo_inc;
                // Revoke on the edge where the count reaches the limit, so the
                // grant is visible for exactly GRANT_TIMEOUT cycles.
                if (bus.B_UTIL) begin
                    state_d = UTIL;
                end else if (!bus.B_REQ[gnt_idx_q] || tmo_inc == TW'(GRANT_TIMEOUT)) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            UTIL: begin
                if (bus.B_DONE) begin
                    grant_d  = '0;
                    rr_ptr_d = gnt_idx_q;
                    state_d  = IDLE;
                end else if (|bus.B_SBSY) begin
                    spl_mst_d = gnt_idx_q;
                    spl_slv_d = sbsy_idx;
                    grant_d   = '0;
                    split_d   = 1'b1;
                    state_d   = SPLIT;
                end
            end
            SPLIT: begin
                if (spl_rdy_q) begin
                    grant_d   = mst_onehot;
                    gnt_idx_d = spl_mst_q;
                    resume_d  = 1'b1;
                    spl_rdy_d = 1'b0;
                    state_d   = SPLIT_RESUME;
                end else if (pick_found) begin
                    grant_d   = pick_grant;
                    gnt_idx_d = pick_idx;
                    state_d   = SPLIT_UTIL;
                end
            end
            SPLIT_UTIL: begin
                if (bus.B_DONE) begin
                    rr_ptr_d = gnt_idx_q;
                    if (spl_rdy_q || rdy_hit) begin
                        grant_d   = mst_onehot;
                        gnt_idx_d = spl_mst_q;
                        resume_d  = 1'b1;
                        spl_rdy_d = 1'b0;
                        state_d   = SPLIT_RESUME;
                    end else begin
                        grant_d = '0;
                        state_d = SPLIT;
                    end
                end
            end
            SPLIT_RESUME: begin
                if (bus.B_DONE) begin
                    grant_d  = '0;
                    split_d  = 1'b0;
                    resume_d = 1'b0;
                    rr_ptr_d = gnt_idx_q;
                    state_d  = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            split_q   <= 1'b0;
            resume_q  <= 1'b0;
            spl_rdy_q <= 1'b0;
            tmo_q     <= '0;
            spl_mst_q <= '0;
            spl_slv_q <= '0;
            rr_ptr_q  <= MW'(NUM_MASTERS - 1);
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            split_q   <= split_d;
            resume_q  <= resume_d;
            spl_rdy_q <= spl_rdy_d;
            tmo_q     <= tmo_d;
            spl_mst_q <= spl_mst_d;
            spl_slv_q <= spl_slv_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign bus.B_GRANT      = grant_q;
    assign bus.B_SPLIT      = split_q;
    assign bus.B_SPL_RESUME = resume_q;
endmodule

// File: tb/tb_bus_arbiter_nx.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter driven by directed vectors.
module tb_bus_arbiter_nx;
    logic clk;
    logic rstn;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    event chk_ev;

    typedef struct {
        int         tag;
        int         dut;
        logic [3:0] grant;
        logic       split;
        logic       resume;
        string      name;
    } sb_t;

    sb_t        sbq[$];
    sb_t        e;
    logic [3:0] ag;
    logic       as_, ar_;
    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    bus_arbiter_nx_if #(.NUM_MASTERS(4), .NUM_SLAVES(3)) ifa ();
    bus_arbiter_nx_if #(.NUM_MASTERS(4), .NUM_SLAVES(3)) ifb ();

    bus_arbiter_nx #(
        .NUM_MASTERS(4), .NUM_SLAVES(3), .PRIO_MODE(0), .GRANT_TIMEOUT(15)
    ) dut_fix (
        .CLK (clk),
        .RSTN(rstn),
        .bus (ifa)
    );

    bus_arbiter_nx #(
        .NUM_MASTERS(4), .NUM_SLAVES(3), .PRIO_MODE(1), .GRANT_TIMEOUT(15)
    ) dut_rr (
        .CLK (clk),
        .RSTN(rstn),
        .bus (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input int d, input logic [3:0] req, input logic [1:0] ud,
                        input logic [2:0] sbsy, input logic [2:0] rdy,
                        input logic [3:0] eg, input logic [1:0] sr, input string nm);
        if (d == 0) begin
            ifa.B_REQ = req; ifa.B_UTIL = ud[1]; ifa.B_DONE = ud[0];
            ifa.B_SBSY = sbsy; ifa.B_SPL_RDY = rdy;
        end else begin
            ifb.B_REQ = req; ifb.B_UTIL = ud[1]; ifb.B_DONE = ud[0];
            ifb.B_SBSY = sbsy; ifb.B_SPL_RDY = rdy;
        end
        sbq.push_back('{cyc + 1, d, eg, sr[1], sr[0], nm});
        @(posedge clk); #1;
    endtask

    // Monitor: compares queued expectations when their cycle comes up.
    initial begin
        forever begin
            @(negedge clk or chk_ev);
            checks++;
            if (!$onehot0(ifa.B_GRANT) || !$onehot0(ifb.B_GRANT)) begin
                errors++;
                $display("FAIL onehot: got fix=%b rr=%b, expected at most one bit set",
                         ifa.B_GRANT, ifb.B_GRANT);
            end
            while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
                e = sbq.pop_front();
                if (e.dut == 0) begin
                    ag = ifa.B_GRANT; as_ = ifa.B_SPLIT; ar_ = ifa.B_SPL_RESUME;
                end else begin
                    ag = ifb.B_GRANT; as_ = ifb.B_SPLIT; ar_ = ifb.B_SPL_RESUME;
                end
                checks++;
                if (e.tag != cyc || ag !== e.grant || as_ !== e.split || ar_ !== e.resume) begin
                    errors++;
                    $display("FAIL %s: got grant=%b split=%b resume=%b, expected grant=%b split=%b resume=%b (cycle %0d, due %0d)",
                             e.name, ag, as_, ar_, e.grant, e.split, e.resume, cyc, e.tag);
                end
            end
        end
    end

    initial begin
        rstn = 1'b1;
        ifa.B_REQ = '0; ifa.B_UTIL = 1'b0; ifa.B_DONE = 1'b0; ifa.B_SBSY = '0; ifa.B_SPL_RDY = '0;
        ifb.B_REQ = '0; ifb.B_UTIL = 1'b0; ifb.B_DONE = 1'b0; ifb.B_SBSY = '0; ifb.B_SPL_RDY = '0;
        #2 rstn = 1'b0;
        @(posedge clk); #1;
        sbq.push_back('{cyc, 0, 4'b0000, 1'b0, 1'b0, "R_reset_fix"});
        sbq.push_back('{cyc, 1, 4'b0000, 1'b0, 1'b0, "R_reset_rr"});
        @(posedge clk); #1;
        rstn = 1'b1;

        // Fixed priority: lowest index wins, then master 2 once master 1 drops out.
        step(0, 4'b0110, 2'b00, 3'b000, 3'b000, 4'b0010, 2'b00, "A_fixed_low");
        step(0, 4'b0110, 2'b10, 3'b000, 3'b000, 4'b0010, 2'b00, "A_util_hold");
        step(0, 4'b0110, 2'b01, 3'b000, 3'b000, 4'b0000, 2'b00, "A_done_idle");
        step(0, 4'b0100, 2'b00, 3'b000, 3'b000, 4'b0100, 2'b00, "A_next_m2");
        step(0, 4'b0100, 2'b10, 3'b000, 3'b000, 4'b0100, 2'b00, "A_m2_util");
        step(0, 4'b0000, 2'b01, 3'b000, 3'b000, 4'b0000, 2'b00, "A_m2_done");

        // Round-robin rotation with all masters requesting.
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b1111, 2'b00, 3'b000, 3'b000, rr_exp[i], 2'b00, "B_rr_grant");
            step(1, 4'b1111, 2'b10, 3'b000, 3'b000, rr_exp[i], 2'b00, "B_rr_util");
            step(1, 4'b1111, 2'b01, 3'b000, 3'b000, 4'b0000, 2'b00, "B_rr_done");
        end
        step(1, 4'b0000, 2'b00, 3'b000, 3'b000, 4'b0000, 2'b00, "B_rr_idle");

        // Grant timeout: 15 cycles of grant, gone in cycle 16; then a request drop.
        step(0, 4'b0010, 2'b00, 3'b000, 3'b000, 4'b0010, 2'b00, "C_grant");
        for (int i = 2; i <= 15; i++) begin
            step(0, 4'b0010, 2'b00, 3'b000, 3'b000, 4'b0010, 2'b00, "C_wait");
        end
        step(0, 4'b0010, 2'b00, 3'b000, 3'b000, 4'b0000, 2'b00, "C_timeout");
        step(0, 4'b0000, 2'b00, 3'b000, 3'b000, 4'b0000, 2'b00, "C_idle");
        step(0, 4'b0010, 2'b00, 3'b000, 3'b000, 4'b0010, 2'b00, "C_regrant");
        step(0, 4'b0000, 2'b00, 3'b000, 3'b000, 4'b0000, 2'b00, "C_req_drop");

        // Split on slave 2, master 3 borrows the bus, ready pulse mid-transfer.
        step(0, 4'b0001, 2'b00, 3'b000, 3'b000, 4'b0001, 2'b00, "D_grant_m0");
        step(0, 4'b0001, 2'b10, 3'b000, 3'b000, 4'b0001, 2'b00, "D_util_m0");
        step(0, 4'b0001, 2'b00, 3'b100, 3'b000, 4'b0000, 2'b10, "D_split_enter");
        step(0, 4'b1001, 2'b00, 3'b011, 3'b000, 4'b1000, 2'b10, "D_grant_m3");
        step(0, 4'b1001, 2'b10, 3'b001, 3'b000, 4'b1000, 2'b10, "D_m3_busy");
        step(0, 4'b1001, 2'b00, 3'b000, 3'b100, 4'b1000, 2'b10, "D_rdy_pulse");
        step(0, 4'b1001, 2'b01, 3'b000, 3'b000, 4'b0001, 2'b11, "D_resume");
        step(0, 4'b0001, 2'b00, 3'b000, 3'b000, 4'b0001, 2'b11, "D_resume_hold");
        step(0, 4'b0000, 2'b01, 3'b000, 3'b000, 4'b0000, 2'b00, "D_resume_done");

        // Split on lowest busy slave (0); hold with only the owner requesting.
        step(0, 4'b0100, 2'b00, 3'b000, 3'b000, 4'b0100, 2'b00, "H_grant_m2");
        step(0, 4'b0100, 2'b10, 3'b000, 3'b000, 4'b0100, 2'b00, "H_util_m2");
        step(0, 4'b0100, 2'b00, 3'b011, 3'b000, 4'b0000, 2'b10, "H_split_slv0");
        step(0, 4'b0100, 2'b00, 3'b000, 3'b110, 4'b0000, 2'b10, "H_hold_masked");
        step(0, 4'b0100, 2'b00, 3'b000, 3'b000, 4'b0000, 2'b10, "H_other_rdy_ignored");
        step(0, 4'b0100, 2'b00, 3'b000, 3'b001, 4'b0000, 2'b10, "H_rdy_slv0");
        step(0, 4'b0100, 2'b00, 3'b000, 3'b000, 4'b0100, 2'b11, "H_resume");
        step(0, 4'b0000, 2'b01, 3'b000, 3'b000, 4'b0000, 2'b00, "H_done");

        // B_DONE beats B_SBSY in the same UTIL cycle.
        step(0, 4'b0001, 2'b00, 3'b000, 3'b000, 4'b0001, 2'b00, "E_grant");
        step(0, 4'b0001, 2'b10, 3'b000, 3'b000, 4'b0001, 2'b00, "E_util");
        step(0, 4'b0001, 2'b01, 3'b001, 3'b000, 4'b0000, 2'b00, "E_done_wins");
        step(0, 4'b0000, 2'b00, 3'b000, 3'b000, 4'b0000, 2'b00, "E_idle");

        // Ready arriving in the same cycle as the borrower's B_DONE.
        step(0, 4'b0001, 2'b00, 3'b000, 3'b000, 4'b0001, 2'b00, "F_grant");
        step(0, 4'b0001, 2'b10, 3'b000, 3'b000, 4'b0001, 2'b00, "F_util");
        step(0, 4'b0001, 2'b00, 3'b010, 3'b000, 4'b0000, 2'b10, "F_split_slv1");
        step(0, 4'b0101, 2'b00, 3'b000, 3'b000, 4'b0100, 2'b10, "F_grant_m2");
        step(0, 4'b0101, 2'b01, 3'b000, 3'b010, 4'b0001, 2'b11, "F_same_cycle_rdy");
        step(0, 4'b0000, 2'b01, 3'b000, 3'b000, 4'b0000, 2'b00, "F_done");

        // Borrower done without ready, borrow again, then async reset in SPLIT_UTIL.
        step(0, 4'b0001, 2'b00, 3'b000, 3'b000, 4'b0001, 2'b00, "G_grant");
        step(0, 4'b0001, 2'b10, 3'b000, 3'b000, 4'b0001, 2'b00, "G_util");
        step(0, 4'b0001, 2'b00, 3'b001, 3'b000, 4'b0000, 2'b10, "G_split");
        step(0, 4'b1001, 2'b00, 3'b000, 3'b000, 4'b1000, 2'b10, "G_split_util");
        step(0, 4'b1001, 2'b01, 3'b000, 3'b000, 4'b0000, 2'b10, "G_back_to_split");
        step(0, 4'b1001, 2'b00, 3'b000, 3'b000, 4'b1000, 2'b10, "G_split_util2");
        @(negedge clk); #2;
        ifa.B_DONE = 1'b1; ifa.B_SPL_RDY = 3'b001;
        rstn = 1'b0;
        sbq.push_back('{cyc, 0, 4'b0000, 1'b0, 1'b0, "G_async_rst"});
        #1 -> chk_ev;
        @(posedge clk); #1;
        rstn = 1'b1;
        step(0, 4'b0000, 2'b01, 3'b000, 3'b001, 4'b0000, 2'b00, "G_no_resume");
        step(0, 4'b0000, 2'b00, 3'b000, 3'b000, 4'b0000, 2'b00, "G_idle");
        step(1, 4'b1111, 2'b00, 3'b000, 3'b000, 4'b0001, 2'b00, "G_rr_restart");
        step(1, 4'b0000, 2'b00, 3'b000, 3'b000, 4'b0000, 2'b00, "G_rr_drop");

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
